// File: rtl/pwm_pkg.sv
// pwm_pkg: shared state encoding and default duty width for the PWM controller.
// Revision 1.0
`default_nettype none

package pwm_pkg;

   localparam int PWM_IN_SIZE_DEF = 10;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_RAMP = 2'd2,
      ST_STOP = 2'd3
   } state_e;

endpackage

`default_nettype wire

// File: rtl/pwm_prescaler.sv
// pwm_prescaler: one-clk ce pulse every prescale+1 clks; ce held high when prescale=0.
// Revision 1.0
`default_nettype none

module pwm_prescaler #(
   parameter int PRESCALE_W = 8
) (
   input  logic                  clk,
   input  logic                  synch_reset_n,
   input  logic [PRESCALE_W-1:0] prescale,
   output logic                  ce
);

   logic [PRESCALE_W-1:0] cnt_q;
   logic [PRESCALE_W-1:0] period_q;
   logic                  ce_q;

   // The period is latched only at wrap, so a new prescale starts after the next ce.
   always_ff @(posedge clk) begin
      if (!synch_reset_n) begin
         cnt_q    <= '0;
         period_q <= '0;
         ce_q     <= 1'b0;
      end else if (cnt_q == period_q) begin
         cnt_q    <= '0;
         period_q <= prescale;
         ce_q     <= 1'b1;
      end else begin
         cnt_q    <= cnt_q + 1'b1;
         ce_q     <= 1'b0;
      end
   end

   assign ce = ce_q;

endmodule

`default_nettype wire

// File: rtl/pwm_ctrl.sv
// pwm_ctrl: run/ramp/stop sequencer with round-robin duty requests and slew-limited duty.
// Revision 1.0
`default_nettype none

module pwm_ctrl
   import pwm_pkg::*;
#(
   parameter int          PWM_IN_SIZE = PWM_IN_SIZE_DEF,
   parameter int          PRESCALE_W  = 8,
   parameter int unsigned STEP_MAX    = 16
) (
   input  logic                          clk,
   input  logic                          synch_reset_n,
   input  logic [PRESCALE_W-1:0]         prescale,
   input  logic                          enable,
   input  logic                          estop,
   input  logic                          req_a_valid,
   input  logic signed [PWM_IN_SIZE-1:0] req_a_data,
   output logic                          req_a_ready,
   input  logic                          req_b_valid,
   input  logic signed [PWM_IN_SIZE-1:0] req_b_data,
   output logic                          req_b_ready,
   output logic                          ce,
   output logic                          oe,
   output logic signed [PWM_IN_SIZE-1:0] duty_out,
   output logic                          period_start,
   output logic [1:0]                    state
);

   localparam int CNT_W = PWM_IN_SIZE - 1;
   localparam logic [CNT_W-1:0] UPD_PT = {{(CNT_W-1){1'b1}}, 1'b0};
   localparam logic signed [PWM_IN_SIZE:0] STEP_S = (PWM_IN_SIZE+1)'(STEP_MAX);

   logic                          ce_w;
   logic [CNT_W-1:0]              pcnt_q;
   logic                          ps_q;
   state_e                        state_q;
   logic                          oe_q;
   logic                          rdy_a_q, rdy_b_q, rr_q;
   logic signed [PWM_IN_SIZE-1:0] duty_q, target_q, duty_d;
   logic signed [PWM_IN_SIZE:0]   duty_x, tgt_x, diff, sum;
   logic                          upd, acc_a, acc_b, rr_d, rdy_a_d, rdy_b_d;

   pwm_prescaler #(.PRESCALE_W(PRESCALE_W)) u_prescaler (
      .clk           (clk),
      .synch_reset_n (synch_reset_n),
      .prescale      (prescale),
      .ce            (ce_w)
   );

   always_ff @(posedge clk) begin
      if (!synch_reset_n) begin
         pcnt_q <= '0;
         ps_q   <= 1'b0;
      end else begin
         ps_q <= ce_w && (pcnt_q == '1);
         if (ce_w) pcnt_q <= pcnt_q + 1'b1;
      end
   end

   // One extra bit keeps target-duty exact across the full signed range.
   always_comb begin
      duty_x = duty_q;
      tgt_x  = target_q;
      diff   = tgt_x - duty_x;
      if (diff > STEP_S)       sum = duty_x + STEP_S;
      else if (diff < -STEP_S) sum = duty_x - STEP_S;
      else                     sum = tgt_x;
      duty_d = $signed(sum[PWM_IN_SIZE-1:0]);
   end

   assign upd   = ce_w && (pcnt_q == UPD_PT);
   assign acc_a = rdy_a_q & req_a_valid;
   assign acc_b = rdy_b_q & req_b_valid;
   // rr_q=1 gives B priority on the next contested cycle.
   assign rr_d    = acc_a ? 1'b1 : (acc_b ? 1'b0 : rr_q);
   assign rdy_a_d = req_a_valid & (~req_b_valid | ~rr_d);
   assign rdy_b_d = req_b_valid & (~req_a_valid | rr_d);

   always_ff @(posedge clk) begin
      if (!synch_reset_n) begin
         state_q  <= ST_IDLE;
         oe_q     <= 1'b0;
         duty_q   <= '0;
         target_q <= '0;
         rdy_a_q  <= 1'b0;
         rdy_b_q  <= 1'b0;
         rr_q     <= 1'b0;
      end else if (estop) begin
         state_q  <= ST_STOP;
         oe_q     <= 1'b0;
         duty_q   <= '0;
         target_q <= '0;
         rdy_a_q  <= 1'b0;
         rdy_b_q  <= 1'b0;
      end else begin
         rdy_a_q <= 1'b0;
         rdy_b_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               target_q <= '0;
               if (enable) begin
                  state_q <= ST_RUN;
                  oe_q    <= 1'b1;
                  rdy_a_q <= rdy_a_d;
                  rdy_b_q <= rdy_b_d;
               end
            end
            ST_RUN: begin
               rr_q <= rr_d;
               if (upd) duty_q <= duty_d;
               if (!enable) begin
                  state_q  <= ST_RAMP;
                  target_q <= '0;
               end else begin
                  rdy_a_q <= rdy_a_d;
                  rdy_b_q <= rdy_b_d;
                  if (acc_a)      target_q <= req_a_data;
                  else if (acc_b) target_q <= req_b_data;
               end
            end
            ST_RAMP: begin
               if (upd) duty_q <= duty_d;
               if (enable) begin
                  state_q <= ST_RUN;
                  rdy_a_q <= rdy_a_d;
                  rdy_b_q <= rdy_b_d;
               end else if (upd && duty_q == '0) begin
                  state_q <= ST_IDLE;
                  oe_q    <= 1'b0;
               end
            end
            ST_STOP: begin
               if (!enable) state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign req_a_ready  = rdy_a_q;
   assign req_b_ready  = rdy_b_q;
   assign ce           = ce_w;
   assign oe           = oe_q;
   assign duty_out     = duty_q;
   assign period_start = ps_q;
   assign state        = state_q;

endmodule

`default_nettype wire
